output_port_arbiter: RTL
========================

// Module: output_port_arbiter
// PURPOSE
// - Per-output-port arbiter of the VC switch. It takes per-input VC/priority request vectors from the input
//   queues and picks one input and one VC (strict priority, then round-robin over inputs).
// - Holds the grant with cts until the packet's last beat, then re-arbitrates.
// - Aborts a grant if the winning request is withdrawn before the first beat.
// PARAMETERS
// - vc_num     3  virtual channels per priority level
// - prio_num   2  priority levels; level prio_num-1 is highest
// - input_num  4  switch inputs competing for this output
// PORTS
// - clk               in   1                          clock; all state on posedge
// - resetn            in   1                          asynchronous active-low reset
// - i_request         in   input_num*vc_num*prio_num  flat; input k owns slice [k*VP +: VP], VP=vc_num*prio_num;
//                                                     bit b = prio*vc_num+vc
// - i_credit_avail    in   VP                         downstream credit present per VC/prio bit
// - i_valid           in   1                          data beat accepted on the granted input this cycle
// - i_last            in   1                          qualifies i_valid; final beat of packet
// - o_cts             out  1                          clear-to-send to the granted input
// - o_selected_input  out  $clog2(input_num)          granted input index
// - o_selected_vc     out  $clog2(VP)                 granted bit index b
// - o_grant           out  input_num                  one-hot copy of o_selected_input while o_cts, else 0
// BEHAVIOUR
// - Reset: state IDLE, o_cts=0, o_selected_input=0, o_selected_vc=0, o_grant=0, all rr pointers=0.
//   Async assert clears immediately, including mid-packet.
// - Eligibility: input k, bit b is eligible iff i_request[k][b] & i_credit_avail[b].
// - Winning level: highest prio with any eligible bit on any input.
// - Input choice: round-robin inside the winning level. Search starts at rr_ptr[level] and wraps modulo
//   input_num.
// - VC choice: lowest vc index eligible at the winning level on the chosen input.
// - FSM IDLE:
//   - evaluates eligibility every cycle.
//   - If any bit is eligible: register the winner and go to GRANT. o_cts=1 from the next cycle
//     (1-cycle request->cts latency).
// - FSM GRANT:
//   - o_cts=1, selection outputs stable.
//   - first_beat flag: set on reset/entry, cleared by the first i_valid.
//   - Withdrawal before any beat (first_beat=1 & i_request[sel][vc]==0): go to IDLE, o_cts=0 next cycle,
//     rr_ptr unchanged.
//   - Request changes after first beat are ignored.
//   - i_credit_avail is not rechecked after the grant.
// - Completion: i_valid & i_last in GRANT -> IDLE; o_cts=0 next cycle; rr_ptr[level] = sel+1 (wrap to 0 at
//   input_num).
// - Single-beat packet (valid&last on the first cts cycle): legal, same completion rule.
// - Withdrawal and valid&last in the same cycle: completion wins.
// - i_valid outside GRANT is ignored.
// - Minimum one IDLE cycle between grants. A request arriving together with last is arbitrated in that
//   IDLE cycle.
// - No eligible bit: stay in IDLE, outputs hold reset values except o_selected_* keep the last value
//   (don't-care when o_cts=0).
// STRUCTURE
// - Package output_arbiter_pkg:
//   - state enum {IDLE, GRANT}
//   - function bit_idx(prio,vc)=prio*vc_num+vc
//   - localparam VP
// - Sub-module rr_arbiter #(N): request vector + start pointer -> one-hot grant + index + any.
//   Combinational; instantiated prio_num times.
//   Top level holds FSM, pointers, priority select and VC pick.
// TESTING
// - Inputs 0 and 2 request bit 1 (prio0) continuously, all credits=1, 1-beat packets
//   -> grants alternate 0,2,0,2; cts rises 1 cycle after IDLE.
// - Input 1 requests bit 0 (prio0), input 3 requests bit 4 (prio1) same cycle -> input 3, vc 4 granted
//   first; input 1 next.
// - Input 0 requests bits 3 and 5, credit_avail[3]=0 -> o_selected_vc=5.
//   Credit for all input-0 bits at 0 -> no cts.
// - Input 2 granted, request drops before i_valid -> o_cts=0 next cycle; pointer still 2, so input 2
//   wins again when it re-requests.
// - 4-beat packet on input 1, request dropped after beat 1 -> cts held until valid&last on beat 4,
//   then IDLE.
// - resetn pulsed low mid-packet -> o_cts and o_grant go 0 without a clock edge; after release, first
//   grant starts search at input 0.

Source files
------------

// File: rtl/output_port_arbiter_pkg.sv
// Shared types and sizing for the per-output-port arbiter of the VC switch.
// The request/credit bit layout is b = prio*vc_num + vc.
package output_arbiter_pkg;

    localparam int unsigned VC_NUM    = 3;
    localparam int unsigned PRIO_NUM  = 2;
    localparam int unsigned INPUT_NUM = 4;
    localparam int unsigned VP        = VC_NUM * PRIO_NUM;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    function automatic int unsigned bit_idx(
        input int unsigned prio,
        input int unsigned vc,
        input int unsigned nvc = VC_NUM
    );
        return prio * nvc + vc;
    endfunction

endpackage

// File: rtl/output_port_arbiter_rr.sv
// Combinational round-robin picker: first set request at or after i_ptr, wrapping modulo N.
module rr_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         i_req,
    input  logic [$clog2(N)-1:0] i_ptr,
    output logic [N-1:0]         o_grant,
    output logic [$clog2(N)-1:0] o_idx,
    output logic                 o_any
);

    localparam int unsigned IW = $clog2(N);

    int unsigned w_j;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_j     = 0;
        for (int unsigned off = 0; off < N; off++) begin
            w_j = (32'(i_ptr) + off) % N;
            if (!o_any && i_req[w_j]) begin
                o_any        = 1'b1;
                o_idx        = IW'(w_j);
                o_grant[w_j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/output_port_arbiter.sv
// Output-port arbiter: strict priority across levels, round-robin over inputs within a level,
// lowest eligible VC on the winner; grant held until the last beat or an early withdrawal.
module output_port_arbiter
    import output_arbiter_pkg::*;
#(
    parameter int unsigned vc_num    = VC_NUM,
    parameter int unsigned prio_num  = PRIO_NUM,
    parameter int unsigned input_num = INPUT_NUM
) (
    input  logic                                   clk,
    input  logic                                   resetn,
    input  logic [input_num*vc_num*prio_num-1:0]   i_request,
    input  logic [vc_num*prio_num-1:0]             i_credit_avail,
    input  logic                                   i_valid,
    input  logic                                   i_last,
    output logic                                   o_cts,
    output logic [$clog2(input_num)-1:0]           o_selected_input,
    output logic [$clog2(vc_num*prio_num)-1:0]     o_selected_vc,
    output logic [input_num-1:0]                   o_grant
);

    localparam int unsigned LVP = vc_num * prio_num;
    localparam int unsigned IW  = $clog2(input_num);
    localparam int unsigned BW  = $clog2(LVP);
    localparam int unsigned LW  = (prio_num > 1) ? $clog2(prio_num) : 1;

    arb_state_e                    r_state;
    logic                          r_cts;
    logic [IW-1:0]                 r_sel_in;
    logic [BW-1:0]                 r_sel_vc;
    logic [LW-1:0]                 r_sel_lvl;
    logic [input_num-1:0]          r_grant;
    logic                          r_first_beat;
    logic [prio_num-1:0][IW-1:0]   r_rr_ptr;

    logic [LVP-1:0]                w_req_in [input_num];
    logic [LVP-1:0]                w_elig   [input_num];
    logic [prio_num-1:0][input_num-1:0] w_lvl_req;
    logic [prio_num-1:0][input_num-1:0] w_lvl_grant;
    logic [prio_num-1:0][IW-1:0]   w_lvl_idx;
    logic [prio_num-1:0]           w_lvl_any;

    logic                          w_any;
    int unsigned                   w_lvl_i;
    int unsigned                   w_vc_i;
    logic                          w_vc_found;
    logic [LW-1:0]                 w_win_lvl;
    logic [IW-1:0]                 w_win_in;
    logic [input_num-1:0]          w_win_oh;
    logic [BW-1:0]                 w_win_bit;
    logic                          w_sel_req;
    logic [IW-1:0]                 w_next_ptr;

    always_comb begin
        for (int unsigned k = 0; k < input_num; k++) begin
            w_req_in[k] = i_request[k*LVP +: LVP];
            w_elig[k]   = w_req_in[k] & i_credit_avail;
        end
    end

    always_comb begin
        w_lvl_req = '0;
        for (int unsigned p = 0; p < prio_num; p++) begin
            for (int unsigned k = 0; k < input_num; k++) begin
                w_lvl_req[p][k] = |w_elig[k][p*vc_num +: vc_num];
            end
        end
    end

    for (genvar p = 0; p < prio_num; p++) begin : g_rr
        rr_arbiter #(.N(input_num)) u_rr (
            .i_req   (w_lvl_req[p]),
            .i_ptr   (r_rr_ptr[p]),
            .o_grant (w_lvl_grant[p]),
            .o_idx   (w_lvl_idx[p]),
            .o_any   (w_lvl_any[p])
        );
    end

    // Ascending scan with overwrite leaves the highest active level as winner.
    always_comb begin
        w_any    = 1'b0;
        w_lvl_i  = 0;
        w_win_in = '0;
        w_win_oh = '0;
        for (int unsigned p = 0; p < prio_num; p++) begin
            if (w_lvl_any[p]) begin
                w_any    = 1'b1;
                w_lvl_i  = p;
                w_win_in = w_lvl_idx[p];
                w_win_oh = w_lvl_grant[p];
            end
        end
        w_vc_found = 1'b0;
        w_vc_i     = 0;
        for (int unsigned v = 0; v < vc_num; v++) begin
            if (!w_vc_found && w_elig[w_win_in][w_lvl_i*vc_num + v]) begin
                w_vc_found = 1'b1;
                w_vc_i     = v;
            end
        end
        w_win_lvl = LW'(w_lvl_i);
        w_win_bit = BW'(bit_idx(w_lvl_i, w_vc_i, vc_num));
    end

    assign w_sel_req  = w_req_in[r_sel_in][r_sel_vc];
    assign w_next_ptr = (r_sel_in == IW'(input_num - 1)) ? '0 : r_sel_in + 1'b1;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= IDLE;
            r_cts        <= 1'b0;
            r_sel_in     <= '0;
            r_sel_vc     <= '0;
            r_sel_lvl    <= '0;
            r_grant      <= '0;
            r_first_beat <= 1'b1;
            r_rr_ptr     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_state      <= GRANT;
                        r_cts        <= 1'b1;
                        r_sel_in     <= w_win_in;
                        r_sel_vc     <= w_win_bit;
                        r_sel_lvl    <= w_win_lvl;
                        r_grant      <= w_win_oh;
                        r_first_beat <= 1'b1;
                    end
                end
                GRANT: begin
                    // Completion is tested first so it beats a same-cycle withdrawal.
                    if (i_valid && i_last) begin
                        r_state             <= IDLE;
                        r_cts               <= 1'b0;
                        r_grant             <= '0;
                        r_rr_ptr[r_sel_lvl] <= w_next_ptr;
                    end else if (r_first_beat && !w_sel_req) begin
                        r_state <= IDLE;
                        r_cts   <= 1'b0;
                        r_grant <= '0;
                    end else if (i_valid) begin
                        r_first_beat <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_cts            = r_cts;
    assign o_selected_input = r_sel_in;
    assign o_selected_vc    = r_sel_vc;
    assign o_grant          = r_grant;

endmodule
